// File: rtl/memory_game_core.sv
// memory_game_core: Genius-style memory-sequence engine (storage, input path, timer and controller)
// Optional feature macro: MEMORY_GAME_TIMEOUT_EN enables the per-play timer and the timeout output.
// Ports:
//   clock       rising-edge clock
//   reset       asynchronous active-low reset
//   iniciar     start a game from IDLE, WIN or LOSE
//   botoes      raw key levels, one bit per key
//   pronto      game over (WIN or LOSE)
//   acertou     game won
//   errou       game lost
//   timeout     loss caused by the play timer
//   db_estado   controller state encoding
//   db_rodada   current round index
//   db_endereco current sequence address
//   db_jogada   last registered play
//   db_memoria  stored word at db_endereco
module memory_game_core #(
  parameter int W       = 4,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 3000
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       iniciar,
  input  logic [W-1:0]               botoes,
  output logic                       pronto,
  output logic                       acertou,
  output logic                       errou,
  output logic                       timeout,
  output logic [3:0]                 db_estado,
  output logic [$clog2(DEPTH)-1:0]   db_rodada,
  output logic [$clog2(DEPTH)-1:0]   db_endereco,
  output logic [W-1:0]               db_jogada,
  output logic [W-1:0]               db_memoria
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    PREP      = 4'd1,
    WAIT_PLAY = 4'd2,
    REG_PLAY  = 4'd3,
    CMP       = 4'd4,
    WAIT_NEW  = 4'd5,
    REG_NEW   = 4'd6,
    STORE     = 4'd7,
    NEXT      = 4'd8,
    WIN       = 4'd9,
    LOSE      = 4'd10
  } state_t;
  state_t          state_q, state_d;
  logic [AW-1:0]   rodada_q, rodada_d;
  logic [AW-1:0]   endereco_q, endereco_d;
  logic [W-1:0]    jogada_q, jogada_d;
  logic [W-1:0]    s_bot_q;
  logic            tem_q;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;
  logic            we;
  logic            expired;
  logic            in_wait;
  logic            tem_jogada;
  logic            jogada_feita;
  logic            onehot;
  logic [W-1:0]    mem [DEPTH];
  logic [W-1:0]    mem_rd;
  assign tem_jogada   = |s_bot_q;
  assign jogada_feita = tem_jogada & ~tem_q;
  assign onehot       = tem_jogada && ((s_bot_q & (s_bot_q - W'(1))) == '0);
  assign in_wait      = (state_q == WAIT_PLAY) || (state_q == WAIT_NEW);
  assign mem_rd       = mem[endereco_q];
`ifdef MEMORY_GAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q;
  // Runs only while waiting for a press; any other state clears it, so each WAIT entry starts at zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) timer_q <= '0;
    else        timer_q <= in_wait ? timer_q + TW'(1) : '0;
  end
  assign expired = in_wait && (timer_q == TW'(TIMEOUT - 1));
`else
  assign expired = 1'b0;
`endif
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      rodada_q   <= '0;
      endereco_q <= '0;
      jogada_q   <= '0;
      s_bot_q    <= '0;
      tem_q      <= 1'b0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rodada_q   <= rodada_d;
      endereco_q <= endereco_d;
      jogada_q   <= jogada_d;
      s_bot_q    <= botoes;
      tem_q      <= tem_jogada;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
    end
  end
  // Storage has no reset; only addresses written earlier in the current game are ever compared.
  always_ff @(posedge clock) begin
    if (we) mem[rodada_q] <= jogada_q;
  end
  always_comb begin
    state_d    = state_q;
    rodada_d   = rodada_q;
    endereco_d = endereco_q;
    jogada_d   = jogada_q;
    timeout_d  = timeout_q;
    // Press validity is sampled on the detection cycle, before the key may change.
    valid_d    = jogada_feita ? onehot : valid_q;
    we         = 1'b0;
    case (state_q)
      IDLE: state_d = iniciar ? PREP : IDLE;
      PREP: begin
        rodada_d   = '0;
        endereco_d = '0;
        jogada_d   = '0;
        timeout_d  = 1'b0;
        state_d    = WAIT_NEW;
      end
      WAIT_PLAY: begin
        if (jogada_feita) state_d = REG_PLAY;
        else if (expired) begin
          state_d   = LOSE;
          timeout_d = 1'b1;
        end
      end
      REG_PLAY: begin
        jogada_d = s_bot_q;
        state_d  = CMP;
      end
      CMP: begin
        if (!valid_q || jogada_q != mem_rd) state_d = LOSE;
        else if (endereco_q == rodada_q - AW'(1)) begin
          endereco_d = rodada_q;
          state_d    = WAIT_NEW;
        end else begin
          endereco_d = endereco_q + AW'(1);
          state_d    = WAIT_PLAY;
        end
      end
      WAIT_NEW: begin
        endereco_d = rodada_q;
        if (jogada_feita) state_d = REG_NEW;
        else if (expired) begin
          state_d   = LOSE;
          timeout_d = 1'b1;
        end
      end
      REG_NEW: begin
        if (!valid_q) state_d = LOSE;
        else begin
          jogada_d = s_bot_q;
          state_d  = STORE;
        end
      end
      STORE: begin
        we      = 1'b1;
        state_d = (rodada_q == AW'(DEPTH - 1)) ? WIN : NEXT;
      end
      NEXT: begin
        rodada_d   = rodada_q + AW'(1);
        endereco_d = '0;
        state_d    = WAIT_PLAY;
      end
      WIN, LOSE: state_d = iniciar ? PREP : state_q;
      default: state_d = IDLE;
    endcase
  end
  assign pronto      = (state_q == WIN) || (state_q == LOSE);
  assign acertou     = state_q == WIN;
  assign errou       = state_q == LOSE;
  assign timeout     = errou & timeout_q;
  assign db_estado   = state_q;
  assign db_rodada   = rodada_q;
  assign db_endereco = endereco_q;
  assign db_jogada   = jogada_q;
  // Masked in IDLE so the unreset storage never shows through after reset.
  assign db_memoria  = (state_q == IDLE) ? '0 : mem_rd;
endmodule

// File: tb/tb_memory_game_core.sv
// tb_memory_game_core: directed bench for memory_game_core (W=4, DEPTH=4, TIMEOUT=20)
module tb_memory_game_core;
  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar;
  logic [3:0] botoes;
  logic       pronto, acertou, errou, timeout;
  logic [3:0] db_estado;
  logic [1:0] db_rodada, db_endereco;
  logic [3:0] db_jogada, db_memoria;
  int vectors = 0;
  int miscompares = 0;
  memory_game_core #(.W(4), .DEPTH(4), .TIMEOUT(20)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .botoes(botoes),
    .pronto(pronto), .acertou(acertou), .errou(errou), .timeout(timeout),
    .db_estado(db_estado), .db_rodada(db_rodada), .db_endereco(db_endereco),
    .db_jogada(db_jogada), .db_memoria(db_memoria)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  task automatic press(input logic [3:0] k);
    botoes = k;
    tick(2);
    botoes = 4'd0;
    tick(4);
  endtask
  task automatic start();
    iniciar = 1'b1;
    tick(1);
    iniciar = 1'b0;
    tick(1);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b0;
    iniciar = 1'b0;
    botoes = 4'd0;
    tick(2);
    chk("rst_estado", 32'(db_estado), 0);
    chk("rst_pronto", 32'(pronto), 0);
    chk("rst_acertou", 32'(acertou), 0);
    chk("rst_errou", 32'(errou), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_rodada", 32'(db_rodada), 0);
    chk("rst_endereco", 32'(db_endereco), 0);
    chk("rst_jogada", 32'(db_jogada), 0);
    chk("rst_memoria", 32'(db_memoria), 0);
    reset = 1'b1;
    tick(3);
    chk("idle_hold", 32'(db_estado), 0);
    // full win
    start();
    chk("win_wait_new0", 32'(db_estado), 5);
    press(4'b0001);
    chk("win_r1_estado", 32'(db_estado), 2);
    chk("win_r1_rodada", 32'(db_rodada), 1);
    chk("win_r1_jogada", 32'(db_jogada), 1);
    chk("win_r1_mem0", 32'(db_memoria), 1);
    press(4'b0001);
    chk("win_r1_wait_new", 32'(db_estado), 5);
    chk("win_r1_endereco", 32'(db_endereco), 1);
    press(4'b0010);
    chk("win_r2_rodada", 32'(db_rodada), 2);
    press(4'b0001);
    press(4'b0010);
    chk("win_r2_endereco", 32'(db_endereco), 2);
    press(4'b0100);
    chk("win_r3_rodada", 32'(db_rodada), 3);
    chk("win_r3_mem0", 32'(db_memoria), 1);
    press(4'b0001);
    chk("win_r3_mem1", 32'(db_memoria), 2);
    press(4'b0010);
    chk("win_r3_mem2", 32'(db_memoria), 4);
    press(4'b0100);
    press(4'b1000);
    chk("win_estado", 32'(db_estado), 9);
    chk("win_acertou", 32'(acertou), 1);
    chk("win_pronto", 32'(pronto), 1);
    chk("win_errou", 32'(errou), 0);
    chk("win_rodada", 32'(db_rodada), 3);
    chk("win_mem3", 32'(db_memoria), 8);
    chk("win_jogada", 32'(db_jogada), 8);
    // wrong repeat in round 2
    start();
    press(4'b0001);
    press(4'b0001);
    press(4'b0010);
    press(4'b0001);
    press(4'b0100);
    chk("wrong_estado", 32'(db_estado), 10);
    chk("wrong_errou", 32'(errou), 1);
    chk("wrong_acertou", 32'(acertou), 0);
    chk("wrong_timeout", 32'(timeout), 0);
    chk("wrong_endereco", 32'(db_endereco), 1);
    chk("wrong_jogada", 32'(db_jogada), 4);
    // timeout in WAIT_PLAY; iniciar held meanwhile must be ignored
    start();
    press(4'b0001);
    iniciar = 1'b1;
`ifdef MEMORY_GAME_TIMEOUT_EN
    tick(18);
    iniciar = 1'b0;
    chk("to_before", 32'(db_estado), 2);
    chk("to_before_errou", 32'(errou), 0);
    tick(1);
    chk("to_estado", 32'(db_estado), 10);
    chk("to_errou", 32'(errou), 1);
    chk("to_timeout", 32'(timeout), 1);
    chk("to_pronto", 32'(pronto), 1);
`else
    tick(25);
    iniciar = 1'b0;
    chk("noto_wait", 32'(db_estado), 2);
    chk("noto_timeout", 32'(timeout), 0);
    press(4'b0010);
    chk("noto_lose", 32'(db_estado), 10);
    chk("noto_timeout_lose", 32'(timeout), 0);
`endif
    iniciar = 1'b1;
    tick(1);
    chk("to_prep", 32'(db_estado), 1);
    chk("to_prep_timeout", 32'(timeout), 0);
    iniciar = 1'b0;
    tick(1);
    chk("to_wait_new", 32'(db_estado), 5);
    // multi-key first press
    press(4'b0011);
    chk("multi_estado", 32'(db_estado), 10);
    chk("multi_errou", 32'(errou), 1);
    chk("multi_timeout", 32'(timeout), 0);
    chk("multi_jogada", 32'(db_jogada), 0);
    chk("multi_rodada", 32'(db_rodada), 0);
    chk("multi_nowrite", 32'(db_memoria), 1);
    // held key registers once
    start();
    botoes = 4'b0001;
    tick(10);
    chk("held_estado", 32'(db_estado), 2);
    chk("held_rodada", 32'(db_rodada), 1);
    chk("held_jogada", 32'(db_jogada), 1);
    botoes = 4'd0;
    tick(3);
    chk("held_release", 32'(db_estado), 2);
    chk("held_release_rodada", 32'(db_rodada), 1);
    // asynchronous reset mid-game
    #3;
    reset = 1'b0;
    #1;
    chk("arst_estado", 32'(db_estado), 0);
    chk("arst_pronto", 32'(pronto), 0);
    chk("arst_errou", 32'(errou), 0);
    chk("arst_rodada", 32'(db_rodada), 0);
    chk("arst_endereco", 32'(db_endereco), 0);
    chk("arst_jogada", 32'(db_jogada), 0);
    chk("arst_memoria", 32'(db_memoria), 0);
    tick(1);
    reset = 1'b1;
    tick(1);
    chk("arst_idle", 32'(db_estado), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
